// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - shared state encoding and widths for the knight-flasher sequencer
package knight_pkg;

    localparam int SPEED_W = 4;
    localparam int SWEEP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN_UP   = 3'd2,
        ST_DWELL_HI = 3'd3,
        ST_RUN_DN   = 3'd4,
        ST_DWELL_LO = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // States in which the prescaler is allowed to run
    function automatic logic is_moving(state_t s);
        return (s == ST_RUN_UP) || (s == ST_DWELL_HI) ||
               (s == ST_RUN_DN) || (s == ST_DWELL_LO);
    endfunction

endpackage

// File: rtl/knight_tick.sv
// rtl/knight_tick.sv - programmable prescaler producing a one-cycle tick every BASE_DIV*(speed+1) cycles
module knight_tick
    import knight_pkg::*;
#(
    parameter int BASE_DIV = 4,
    parameter int PRE_W    = 16
) (
    input  logic               ck,
    input  logic               res_n,
    input  logic               clr,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;
    logic [PRE_W-1:0] limit;

    always_comb begin
        limit = PRE_W'(BASE_DIV) * (PRE_W'(speed) + PRE_W'(1)) - PRE_W'(1);
        tick  = en && (cnt_q == limit);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge ck or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/knight_ctrl.sv
// rtl/knight_ctrl.sv - knight-flasher sequencer: load/step/direction/dwell/sweep control
// Optional KNIGHT_CTRL_PAUSE_EN adds a hold input that freezes the sequence.
module knight_ctrl
    import knight_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int BASE_DIV = 4,
    parameter int DWELL    = 2,
    parameter int PRE_W    = 16
) (
    input  logic                     ck,
    input  logic                     res_n,
`ifdef KNIGHT_CTRL_PAUSE_EN
    input  logic                     hold,
`endif
    input  logic                     start,
    input  logic                     stop,
    input  logic [SPEED_W-1:0]       speed,
    input  logic [SWEEP_W-1:0]       sweeps,
    output logic                     load,
    output logic                     shift_en,
    output logic                     shift_up,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     busy,
    output logic                     done
);

    localparam int POS_W = $clog2(WIDTH);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL + 1) : 1;

    logic hold_w;
`ifdef KNIGHT_CTRL_PAUSE_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    state_t               state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 shift_up_q, shift_up_d;
    logic                 shift_en_q, shift_en_d;
    logic                 load_q, load_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [SWEEP_W-1:0]   sweeps_q, sweeps_d;
    logic [SWEEP_W-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic [DW_W-1:0]      dwell_q, dwell_d;
    logic                 tick;
    logic                 step;
    logic                 step_up;

    knight_tick #(
        .BASE_DIV (BASE_DIV),
        .PRE_W    (PRE_W)
    ) u_tick (
        .ck    (ck),
        .res_n (res_n),
        .clr   (state_q == ST_LOAD),
        .en    (is_moving(state_q) && !hold_w),
        .speed (speed_q),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        speed_d     = speed_q;
        sweeps_d    = sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
        dwell_d     = dwell_q;
        step        = 1'b0;
        step_up     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d     = ST_LOAD;
                    speed_d     = speed;
                    sweeps_d    = sweeps;
                    sweep_cnt_d = '0;
                    dwell_d     = '0;
                    pos_d       = '0;
                end
            end
            ST_LOAD: state_d = ST_RUN_UP;
            ST_RUN_UP: begin
                if (tick) begin
                    step    = 1'b1;
                    step_up = 1'b1;
                    pos_d   = pos_q + POS_W'(1);
                    if (pos_q == POS_W'(WIDTH - 2)) begin
                        state_d = (DWELL > 0) ? ST_DWELL_HI : ST_RUN_DN;
                    end
                end
            end
            ST_DWELL_HI: begin
                if (tick) begin
                    if (int'(dwell_q) + 1 >= DWELL) begin
                        dwell_d = '0;
                        state_d = ST_RUN_DN;
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
            end
            ST_RUN_DN: begin
                if (tick) begin
                    step  = 1'b1;
                    pos_d = pos_q - POS_W'(1);
                    if (pos_q == POS_W'(1)) begin
                        sweep_cnt_d = sweep_cnt_q + SWEEP_W'(1);
                        if ((sweeps_q != '0) && (sweep_cnt_q + SWEEP_W'(1) == sweeps_q)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = (DWELL > 0) ? ST_DWELL_LO : ST_RUN_UP;
                        end
                    end
                end
            end
            ST_DWELL_LO: begin
                if (tick) begin
                    if (int'(dwell_q) + 1 >= DWELL) begin
                        dwell_d = '0;
                        state_d = ST_RUN_UP;
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (hold_w) begin
            state_d     = state_q;
            pos_d       = pos_q;
            speed_d     = speed_q;
            sweeps_d    = sweeps_q;
            sweep_cnt_d = sweep_cnt_q;
            dwell_d     = dwell_q;
            step        = 1'b0;
        end

        // Abort wins over everything, including a tick landing in the same cycle
        if (stop && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            pos_d       = pos_q;
            sweep_cnt_d = sweep_cnt_q;
            dwell_d     = '0;
            step        = 1'b0;
        end

        shift_en_d = step;
        load_d     = (state_q == ST_IDLE) && (state_d == ST_LOAD);
        done_d     = (state_q != ST_DONE) && (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);

        // A step keeps the direction it was taken in; the new direction shows up the cycle after
        if (step) begin
            shift_up_d = step_up;
        end else begin
            case (state_d)
                ST_LOAD, ST_RUN_UP, ST_DWELL_HI: shift_up_d = 1'b1;
                ST_RUN_DN, ST_DWELL_LO:          shift_up_d = 1'b0;
                default:                         shift_up_d = shift_up_q;
            endcase
        end
    end

    always_ff @(posedge ck or negedge res_n) begin
        if (!res_n) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            shift_up_q  <= 1'b0;
            shift_en_q  <= 1'b0;
            load_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            speed_q     <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            shift_up_q  <= shift_up_d;
            shift_en_q  <= shift_en_d;
            load_q      <= load_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            speed_q     <= speed_d;
            sweeps_q    <= sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
            dwell_q     <= dwell_d;
        end
    end

    assign load     = load_q;
    assign shift_en = shift_en_q;
    assign shift_up = shift_up_q;
    assign pos      = pos_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_knight_ctrl.sv
// tb/tb_knight_ctrl.sv - directed self-checking bench for knight_ctrl (WIDTH=8, BASE_DIV=4, DWELL=2)
module tb_knight_ctrl;

    logic       ck = 1'b0;
    logic       res_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] speed = 4'd0;
    logic [3:0] sweeps = 4'd0;
    logic       load, shift_en, shift_up, busy, done;
    logic [2:0] pos;
`ifdef KNIGHT_CTRL_PAUSE_EN
    logic       hold = 1'b0;
`endif

    knight_ctrl #(.WIDTH(8), .BASE_DIV(4), .DWELL(2), .PRE_W(16)) dut (
        .ck       (ck),
        .res_n    (res_n),
`ifdef KNIGHT_CTRL_PAUSE_EN
        .hold     (hold),
`endif
        .start    (start),
        .stop     (stop),
        .speed    (speed),
        .sweeps   (sweeps),
        .load     (load),
        .shift_en (shift_en),
        .shift_up (shift_up),
        .pos      (pos),
        .busy     (busy),
        .done     (done)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    int se_cyc[$];
    int se_pos[$];
    int se_up[$];
    int load_n = 0, load_cyc = 0, done_n = 0, done_cyc = 0;
    int n_checks = 0, n_errors = 0;

    // Event log sampled mid-cycle; each negedge is one cycle index
    always @(negedge ck) begin
        cyc++;
        if (shift_en) begin
            se_cyc.push_back(cyc);
            se_pos.push_back(int'(pos));
            se_up.push_back(int'(shift_up));
        end
        if (load) begin
            load_n++;
            load_cyc = cyc;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_c();
        @(posedge ck);
        #2;
    endtask

    task automatic wait_cyc(input int c);
        int guard = 0;
        while (cyc < c && guard < 5000) begin
            step_c();
            guard++;
        end
    endtask

    task automatic clear_log();
        se_cyc.delete();
        se_pos.delete();
        se_up.delete();
        load_n = 0;
        done_n = 0;
    endtask

    task automatic start_run(input int spd, input int swp, output int l);
        speed  = 4'(spd);
        sweeps = 4'(swp);
        clear_log();
        start = 1'b1;
        step_c();
        start = 1'b0;
        for (int i = 0; i < 5 && load_n == 0; i++) step_c();
        check("load_seen", load_n, 1);
        l = load_cyc;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step_c();
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;

        repeat (2) step_c();
        check("rst_busy", int'(busy), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_load", int'(load), 0);
        check("rst_shift_en", int'(shift_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_shift_up", int'(shift_up), 0);
        res_n = 1'b1;
        step_c();

        // Single sweep at speed 0
        start_run(0, 1, l);
        wait_cyc(l + 70);
        check("t2_count", se_cyc.size(), 14);
        for (int i = 0; i < 14; i++) begin
            if (i < se_cyc.size()) begin
                if (i < 7) begin
                    check("t2_up_cyc", se_cyc[i] - l, 5 + 4 * i);
                    check("t2_up_pos", se_pos[i], i + 1);
                    check("t2_up_dir", se_up[i], 1);
                end else begin
                    check("t2_dn_cyc", se_cyc[i] - l, 41 + 4 * (i - 7));
                    check("t2_dn_pos", se_pos[i], 6 - (i - 7));
                    check("t2_dn_dir", se_up[i], 0);
                end
            end
        end
        check("t2_done_n", done_n, 1);
        check("t2_done_cyc", done_cyc - l, 65);
        check("t2_load_n", load_n, 1);
        check("t2_busy", int'(busy), 0);
        check("t2_pos", int'(pos), 0);

        // Speed 3 with a stray start mid-run
        start_run(3, 1, l);
        wait_cyc(l + 19);
        start = 1'b1;
        step_c();
        start = 1'b0;
        wait_cyc(l + 52);
        check("t3_count", se_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < se_cyc.size()) check("t3_cyc", se_cyc[i] - l, 17 + 16 * i);
        end
        check("t3_load_n", load_n, 1);
        check("t3_busy", int'(busy), 1);
        check("t3_pos", int'(pos), 3);
        do_stop();
        check("t3_stop_busy", int'(busy), 0);
        step_c();

        // Endless sweeps, then abort
        start_run(0, 0, l);
        wait_cyc(l + 229);
        check("t4_count", se_cyc.size(), 45);
        if (se_cyc.size() > 41) begin
            check("t4_trip1", se_cyc[13] - l, 65);
            check("t4_trip2", se_cyc[27] - l, 137);
            check("t4_trip3", se_cyc[41] - l, 209);
        end
        check("t4_done_n", done_n, 0);
        check("t4_busy", int'(busy), 1);
        check("t4_pos", int'(pos), 3);
        do_stop();
        check("t4_stop_busy", int'(busy), 0);
        repeat (8) step_c();
        check("t4_frozen_pos", int'(pos), 3);
        check("t4_frozen_count", se_cyc.size(), 45);
        check("t4_no_done", done_n, 0);
        check("t4_idle", int'(busy), 0);

        // Stop coinciding with a tick at pos 4
        start_run(0, 1, l);
        wait_cyc(l + 19);
        check("t5_pre_busy", int'(busy), 1);
        check("t5_pre_pos", int'(pos), 4);
        stop = 1'b1;
        step_c();
        stop = 1'b0;
        check("t5_busy", int'(busy), 0);
        check("t5_shift_en", int'(shift_en), 0);
        check("t5_pos", int'(pos), 4);
        step_c();
        check("t5_count", se_cyc.size(), 4);
        check("t5_done_n", done_n, 0);

        // Asynchronous reset while a step pulse is out
        start_run(0, 1, l);
        wait_cyc(l + 4);
        check("t1_pre_shift_en", int'(shift_en), 1);
        check("t1_pre_pos", int'(pos), 1);
        res_n = 1'b0;
        #1;
        check("t1_busy", int'(busy), 0);
        check("t1_pos", int'(pos), 0);
        check("t1_shift_en", int'(shift_en), 0);
        check("t1_load", int'(load), 0);
        check("t1_done", int'(done), 0);
        check("t1_shift_up", int'(shift_up), 0);
        repeat (2) step_c();
        res_n = 1'b1;
        repeat (70) step_c();
        check("t1_no_done", done_n, 0);
        check("t1_idle", int'(busy), 0);

`ifdef KNIGHT_CTRL_PAUSE_EN
        // Hold for 20 cycles in RUN_DN; the prescaler resumes mid-count
        start_run(0, 1, l);
        wait_cyc(l + 45);
        hold = 1'b1;
        wait_cyc(l + 65);
        hold = 1'b0;
        wait_cyc(l + 90);
        check("t6_count", se_cyc.size(), 14);
        if (se_cyc.size() > 9) begin
            check("t6_before_hold", se_cyc[8] - l, 45);
            check("t6_after_hold", se_cyc[9] - l, 69);
            check("t6_after_pos", se_pos[9], 4);
        end
        check("t6_done_cyc", done_cyc - l, 85);
        check("t6_busy", int'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/knight_ctrl.md
Name: knight_ctrl

Overview:
- Sequencer for the 8-bit knight-flasher shift datapath.
- Generates step pulses, direction, load and end-of-travel dwell from a programmable prescaler, and runs a configured number of round-trip sweeps.
- The datapath (shift register) stays dumb: it loads bit0 on load, and shifts up or down on shift_en.
- Sits between the top-level control (start/stop) and the LED shift register.

Parameters:
WIDTH, 8, datapath bit count; pos range 0..WIDTH-1
BASE_DIV, 4, clock cycles per tick at speed=0
DWELL, 2, ticks held at each end before reversing; 0 = no dwell
PRE_W, 16, prescaler counter width; must hold BASE_DIV*16-1

Ports:
ck  in  1  clock, rising edge
res_n  in  1  reset, asynchronous, active-low
start  in  1  begin run; sampled only in IDLE
stop  in  1  abort run; any non-IDLE state
speed  in  4  latched at start; tick period = BASE_DIV*(speed+1) cycles
sweeps  in  4  latched at start; round trips to run, 0 = endless
load  out  1  one-cycle pulse: datapath loads bit0
shift_en  out  1  one-cycle pulse per step
shift_up  out  1  direction for shift_en: 1 = left/up, 0 = down
pos  out  $clog2(WIDTH)  current lit-bit index
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on sweep-count completion

Behaviour:
- All outputs are registered.
- Reset (res_n=0, async) forces state=IDLE, prescaler=0, dwell=0, sweep_cnt=0, and all outputs to 0 (pos=0, shift_up=0).
- States: IDLE, LOAD, RUN_UP, DWELL_HI, RUN_DN, DWELL_LO, DONE.
- Tick: internal one-cycle strobe when the prescaler reaches BASE_DIV*(speed_r+1)-1. The prescaler then wraps to 0. It counts only in RUN_*/DWELL_* and is cleared on entry to LOAD.
- IDLE: start=1 and stop=0 -> LOAD. Latch speed_r and sweeps_r, sweep_cnt=0.
- LOAD: load=1 for exactly this cycle, pos=0, shift_up=1 -> RUN_UP.
- RUN_UP: on each tick, shift_en=1 for one cycle, shift_up=1, pos+1 on the same edge.
  - When pos becomes WIDTH-1: -> DWELL_HI if DWELL>0, else -> RUN_DN.
- DWELL_HI: count DWELL ticks, no shift_en; then -> RUN_DN with shift_up=0.
- RUN_DN: on each tick, shift_en pulse, pos-1.
  - When pos becomes 0: sweep_cnt+1.
  - If sweeps_r!=0 and sweep_cnt+1==sweeps_r -> DONE.
  - Else -> DWELL_LO (or RUN_UP if DWELL=0).
- DWELL_LO: count DWELL ticks; then -> RUN_UP with shift_up=1.
- DONE: done=1 for one cycle -> IDLE. pos stays 0.
- Datapath contract: datapath shifts on the edge ending the shift_en cycle, so its lit bit equals pos one cycle after pos updates.
- stop:
  - Priority over tick, start and dwell expiry.
  - Any non-IDLE state -> IDLE next edge; no shift_en or done in that cycle.
  - pos holds its last value; busy=0.
- start while busy: ignored. start and stop both high in IDLE: stay IDLE.
- sweep_cnt is 4 bits; with sweeps_r=0 it wraps freely and never ends the run.
- Mid-run reset: async clear as above; no done.

Optional Feature:
- Macro KNIGHT_CTRL_PAUSE_EN.
- Defined:
  - Adds input port hold (1 bit).
  - hold=1 freezes prescaler, dwell counter and state; no tick, no shift_en; outputs hold their values.
  - stop is still honoured during hold. Releasing hold resumes the count where it froze.
- Undefined: port absent; behaviour identical to hold=0.

Decomposition:
- Shared package knight_pkg:
  - state enum (IDLE..DONE) with 3-bit encoding
  - SPEED_W=4, SWEEP_W=4
- One sub-module: knight_tick, a prescaler with ports ck, res_n, clr, en, speed, tick.
- The FSM, dwell counter and sweep counter stay in knight_ctrl.

Test Plan (WIDTH=8, BASE_DIV=4, DWELL=2):
1. Reset: res_n=0 mid-operation -> busy=0, pos=0, load/shift_en/done=0 immediately, without a clock edge.
2. start, speed=0, sweeps=1 -> run completes:
   - load for 1 cycle, then 7 shift_en with shift_up=1 spaced 4 cycles (pos 1..7);
   - 8 quiet cycles of dwell;
   - 7 shift_en with shift_up=0 (pos 6..0);
   - done 1 cycle, then busy=0.
3. speed=3 -> shift_en spacing is 16 cycles; start pulsed while busy changes nothing.
4. sweeps=0 -> run continues past 3 round trips without done; stop -> busy=0 next cycle, no done, pos frozen.
5. stop asserted in the same cycle as a tick in RUN_UP at pos=4 -> no shift_en, pos stays 4, IDLE next cycle.
6. With KNIGHT_CTRL_PAUSE_EN: hold=1 for 20 cycles during RUN_DN -> no shift_en; after release, the next shift_en arrives at the remaining prescaler count, so the period is not restarted.
